spsram_bist: RTL and testbench

Built-in self-test engine for one single-port SRAM bank. It drives the memory's pin-level port (data, address, write enable, chip enable and output enable, all active-high) as the initiator. After a start pulse it writes and reads back two complementary address-derived patterns over the whole address space, then reports pass/fail, an error count and the first failing address. It sits beside each spsram instance and shares the memory port with the functional path through an external mux selected by `o_busy`.

---
 rtl/spsram_bist.sv | 191 +++++++++++++++++++
 tb/tb_spsram_bist.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spsram_bist.sv
// spsram_bist: self-test engine for one single-port SRAM bank.
// Writes P0(a) = SEED ^ a over all addresses and reads it back, then does the
// same with ~P0(a). Reports pass/fail, the error count and the first failing address.
// Optional macro SPSRAM_BIST_SYNC_RD_EN: registered-read memory. This adds one
// compare stage and one DRAIN cycle after the last read.
module spsram_bist #(
    parameter int          BW_DATA = 32,
    parameter int          BW_ADDR = 5,
    parameter logic [31:0] SEED    = 32'hA5A5_A5A5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [7:0]         o_err_cnt,
    output logic [BW_ADDR-1:0] o_fail_addr,
    output logic               o_fail_phase,
    output logic [BW_DATA-1:0] o_mem_data,
    output logic [BW_ADDR-1:0] o_mem_addr,
    output logic               o_mem_wen,
    output logic               o_mem_cen,
    output logic               o_mem_oen,
    input  logic [BW_DATA-1:0] i_mem_data
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR0   = 3'd1;
    localparam logic [2:0] RD0   = 3'd2;
    localparam logic [2:0] WR1   = 3'd3;
    localparam logic [2:0] RD1   = 3'd4;
`ifdef SPSRAM_BIST_SYNC_RD_EN
    localparam logic [2:0] DRAIN = 3'd5;
`endif
    localparam logic [BW_DATA-1:0] SEED_T = SEED[BW_DATA-1:0];

    function automatic logic [BW_DATA-1:0] pat0(input logic [BW_ADDR-1:0] a);
        return SEED_T ^ BW_DATA'(a);
    endfunction

    logic [2:0]         state, state_n;
    logic [BW_ADDR-1:0] addr_n;
    logic               addr_last;
    logic               wr_n, rd_n, drain_n;

    // o_mem_addr doubles as the walk counter; it sits at 0 outside active phases
    assign addr_last = &o_mem_addr;

    // phase sequencing: one address per cycle, wrap to 0 on every phase change
    always_comb begin
        state_n = state;
        addr_n  = o_mem_addr + BW_ADDR'(1);
        case (state)
            IDLE: begin
                addr_n = '0;
                if (i_start) state_n = WR0;
            end
            WR0: if (addr_last) state_n = RD0;
            RD0: if (addr_last) state_n = WR1;
            WR1: if (addr_last) state_n = RD1;
            RD1: if (addr_last) begin
`ifdef SPSRAM_BIST_SYNC_RD_EN
                state_n = DRAIN;
`else
                state_n = IDLE;
`endif
            end
`ifdef SPSRAM_BIST_SYNC_RD_EN
            DRAIN: begin
                addr_n  = '0;
                state_n = IDLE;
            end
`endif
            default: begin
                addr_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign wr_n = (state_n == WR0) || (state_n == WR1);
    assign rd_n = (state_n == RD0) || (state_n == RD1);
`ifdef SPSRAM_BIST_SYNC_RD_EN
    assign drain_n = (state_n == DRAIN);
`else
    assign drain_n = 1'b0;
`endif

    // FSM and registered memory port, all driven from next-state values
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_mem_wen  <= 1'b0;
            o_mem_cen  <= 1'b0;
            o_mem_oen  <= 1'b0;
        end else begin
            state      <= state_n;
            o_busy     <= (state_n != IDLE);
            o_mem_addr <= addr_n;
            o_mem_wen  <= wr_n;
            o_mem_cen  <= wr_n | rd_n;
            o_mem_oen  <= rd_n | drain_n;
            if (state_n == WR0)      o_mem_data <= pat0(addr_n);
            else if (state_n == WR1) o_mem_data <= ~pat0(addr_n);
            else                     o_mem_data <= '0;
        end
    end

    // read descriptor for the access on the port this cycle
    logic               rd_vld, rd_phase, rd_last;
    logic [BW_DATA-1:0] rd_exp;
    assign rd_vld   = (state == RD0) || (state == RD1);
    assign rd_phase = (state == RD1);
    assign rd_last  = rd_phase && addr_last;
    assign rd_exp   = rd_phase ? ~pat0(o_mem_addr) : pat0(o_mem_addr);

    logic               cmp_vld, cmp_phase, cmp_last;
    logic [BW_ADDR-1:0] cmp_addr;
    logic [BW_DATA-1:0] cmp_exp;
`ifdef SPSRAM_BIST_SYNC_RD_EN
    logic               s_vld, s_phase, s_last;
    logic [BW_ADDR-1:0] s_addr;
    logic [BW_DATA-1:0] s_exp;

    // one stage to line up with the memory's registered read data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s_vld   <= 1'b0;
            s_phase <= 1'b0;
            s_last  <= 1'b0;
            s_addr  <= '0;
            s_exp   <= '0;
        end else begin
            s_vld   <= rd_vld;
            s_phase <= rd_phase;
            s_last  <= rd_last;
            s_addr  <= o_mem_addr;
            s_exp   <= rd_exp;
        end
    end
    assign cmp_vld   = s_vld;
    assign cmp_phase = s_phase;
    assign cmp_last  = s_last;
    assign cmp_addr  = s_addr;
    assign cmp_exp   = s_exp;
`else
    assign cmp_vld   = rd_vld;
    assign cmp_phase = rd_phase;
    assign cmp_last  = rd_last;
    assign cmp_addr  = o_mem_addr;
    assign cmp_exp   = rd_exp;
`endif

    logic miscmp;
    assign miscmp = cmp_vld && (i_mem_data != cmp_exp);

    // results: cleared on start acceptance, done/pass once the last compare retires
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_err_cnt    <= '0;
            o_fail_addr  <= '0;
            o_fail_phase <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state == IDLE && i_start) begin
                o_pass       <= 1'b0;
                o_err_cnt    <= '0;
                o_fail_addr  <= '0;
                o_fail_phase <= 1'b0;
            end else if (cmp_vld) begin
                if (miscmp) begin
                    // err_cnt never returns to 0 within a run, so 0 marks "no fail yet"
                    if (o_err_cnt == 8'd0) begin
                        o_fail_addr  <= cmp_addr;
                        o_fail_phase <= cmp_phase;
                    end
                    if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
                end
                if (cmp_last) begin
                    o_done <= 1'b1;
                    o_pass <= (o_err_cnt == 8'd0) && !miscmp;
                end
            end
        end
    end
endmodule

// File: tb/tb_spsram_bist.sv
// Bench for spsram_bist: a faultable SRAM model plus a cycle-indexed reference
// derived from the test schedule (4 phases of N accesses from cycle 1).
`timescale 1ns/1ps
module tb_spsram_bist;
    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 5;
    localparam int N = 1 << BW_ADDR;
    localparam logic [31:0] SEED = 32'hA5A5_A5A5;
`ifdef SPSRAM_BIST_SYNC_RD_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = 4 * N + 1 + SYNC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, pass, fail_phase, wen, cen, oen;
    logic [7:0]  err_cnt;
    logic [4:0]  fail_addr, addr;
    logic [31:0] wdata, rdata;

    spsram_bist #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .SEED(SEED)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt),
        .o_fail_addr(fail_addr), .o_fail_phase(fail_phase),
        .o_mem_data(wdata), .o_mem_addr(addr), .o_mem_wen(wen), .o_mem_cen(cen),
        .o_mem_oen(oen), .i_mem_data(rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // fault injection: read = zero ? 0 : hit ? (stored & f_and) ^ f_xor : stored
    logic        f_zero = 1'b0;
    int          f_addr = 0;
    logic [31:0] f_and  = '1;
    logic [31:0] f_xor  = '0;
    logic [1:0]  f_phen = 2'b00;

    function automatic logic [31:0] pat(int p, int a);
        logic [31:0] v;
        v = SEED ^ 32'(a);
        return (p != 0) ? ~v : v;
    endfunction

    function automatic logic [31:0] mem_read(int p, int a, logic [31:0] stored);
        if (f_zero) return '0;
        if (a == f_addr && f_phen[p]) return (stored & f_and) ^ f_xor;
        return stored;
    endfunction

    function automatic bit bad(int p, int a);
        return mem_read(p, a, pat(p, a)) != pat(p, a);
    endfunction

    // cycle in which the result of reading (p,a) is visible on the outputs
    function automatic int vis_cycle(int p, int a);
        return (2 * p + 1) * N + a + 2 + SYNC;
    endfunction

    function automatic int exp_err(int c);
        int n = 0;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < N; a++)
                if (bad(p, a) && vis_cycle(p, a) <= c && n < 255) n++;
        return n;
    endfunction

    function automatic int first_bad(int c);
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < N; a++)
                if (bad(p, a) && vis_cycle(p, a) <= c) return p * N + a;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    // reference schedule: m_cyc = cycle number within the current run (0 = idle)
    int m_cyc = 0;
    bit m_held = 0;
    int h_err = 0, h_fa = 0, h_fp = 0;
    bit h_pass = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc  <= 0;
            m_held <= 0;
        end else if (m_cyc == 0 || m_cyc == LAT) begin
            if (m_cyc == LAT) begin
                m_held <= 1;
                h_err  <= exp_err(LAT);
                h_fa   <= (first_bad(LAT) < 0) ? 0 : first_bad(LAT) % N;
                h_fp   <= (first_bad(LAT) < 0) ? 0 : first_bad(LAT) / N;
                h_pass <= (exp_err(LAT) == 0);
            end
            m_cyc <= start ? 1 : 0;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    // SRAM model
    logic [31:0] mem [N];
    logic rd_phase;
    assign rd_phase = (m_cyc > 3 * N) && (m_cyc <= 4 * N);
    always @(posedge clk) if (cen && wen) mem[addr] <= wdata;
`ifdef SPSRAM_BIST_SYNC_RD_EN
    logic [31:0] rdq = '0;
    always @(posedge clk)
        if (cen && oen && !wen) rdq <= mem_read(int'(rd_phase), int'(addr), mem[addr]);
    assign rdata = rdq;
`else
    always_comb rdata = mem_read(int'(rd_phase), int'(addr), mem[addr]);
`endif

    // per-cycle compare of every output against the schedule
    always @(negedge clk) begin : cmp
        logic [56:0] act, want;
        logic [31:0] e_data;
        logic [4:0]  e_addr;
        logic e_cen, e_wen, e_oen, e_busy, e_done, e_pass, e_fp;
        int e_err, e_fa, c, ph, a, fb;
        c = m_cyc;
        e_data = '0; e_addr = '0; e_cen = 0; e_wen = 0; e_oen = 0;
        e_err = 0; e_fa = 0; e_fp = 0; e_pass = 0;
        if (c >= 1 && c <= 4 * N) begin
            ph = (c - 1) / N;
            a  = (c - 1) % N;
            e_cen  = 1;
            e_wen  = (ph % 2 == 0);
            e_oen  = (ph % 2 == 1);
            e_addr = 5'(a);
            if (ph == 0)      e_data = pat(0, a);
            else if (ph == 2) e_data = pat(1, a);
        end else if (SYNC == 1 && c == 4 * N + 1) begin
            e_oen = 1;
        end
        e_busy = (c >= 1 && c < LAT);
        e_done = (c == LAT);
        if (c >= 1) begin
            fb     = first_bad(c);
            e_err  = exp_err(c);
            e_fa   = (fb < 0) ? 0 : fb % N;
            e_fp   = (fb >= N);
            e_pass = (c == LAT) && (exp_err(LAT) == 0);
        end else if (m_held) begin
            e_err  = h_err;
            e_fa   = h_fa;
            e_fp   = (h_fp != 0);
            e_pass = h_pass;
        end
        act  = {busy, done, pass, err_cnt, fail_addr, fail_phase, wdata, addr, wen, cen, oen};
        want = {e_busy, e_done, e_pass, 8'(e_err), 5'(e_fa), e_fp, e_data, e_addr, e_wen, e_cen, e_oen};
        chk("cycle", 64'(act), 64'(want));
        if (c == 4)         chk("wr0_a3_data", wdata, 32'hA5A5A5A6);
        if (c == 2 * N + 4) chk("wr1_a3_data", wdata, 32'h5A5A5A59);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_fault(input logic z, input int fa, input logic [31:0] fand,
                             input logic [31:0] fxor, input logic [1:0] phen);
        f_zero = z; f_addr = fa; f_and = fand; f_xor = fxor; f_phen = phen;
    endtask

    // one start pulse; returns the cycle index of o_done (-1 on timeout)
    task automatic run_one(output int dc);
        dc = -1;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int i = 1; i <= 2 * LAT; i++) begin
            @(negedge clk);
            if (done) begin
                dc = i;
                break;
            end
        end
        tests++;
        if (dc < 0) begin
            fails++;
            $display("FAIL done_timeout: got no o_done within %0d cycles", 2 * LAT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, n, fb;
        #2 rst = 1;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_cen", cen, 0);
        rst = 0;
        tick(2);

        // healthy memory
        set_fault(0, 0, '1, '0, 2'b00);
        run_one(dc);
        chk("done_cycle", dc, SYNC ? 130 : 129);
        chk("healthy_pass", pass, 1);
        chk("healthy_err", err_cnt, 0);
        tick(2);

        // bit0 forced to 0 at address 5: only the inverted pattern trips
        set_fault(0, 5, ~32'h1, '0, 2'b11);
        run_one(dc);
        chk("b0_err", err_cnt, 1);
        chk("b0_addr", fail_addr, 5);
        chk("b0_phase", fail_phase, 1);
        chk("b0_pass", pass, 0);
        tick(2);

        // memory always reads 0
        set_fault(1, 0, '1, '0, 2'b00);
        run_one(dc);
        chk("zero_err", err_cnt, 64);
        chk("zero_addr", fail_addr, 0);
        chk("zero_phase", fail_phase, 0);
        chk("zero_pass", pass, 0);
        tick(2);

        // last address, inverted phase only: caught by the very last compare
        set_fault(0, 31, '1, 32'h1, 2'b10);
        run_one(dc);
        chk("a31_err", err_cnt, 1);
        chk("a31_addr", fail_addr, 31);
        chk("a31_phase", fail_phase, 1);
        tick(2);

        // start held: back-to-back runs, results cleared at each restart
        set_fault(1, 0, '1, '0, 2'b00);
        start = 1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("held_done_count", n, 2);
        @(posedge clk);
        #1 start = 0;
        n = 0;
        for (int i = 0; i < 2 * LAT && n == 0; i++) begin
            @(negedge clk);
            if (done) n = 1;
        end
        chk("held_final_done", n, 1);
        tick(2);

        // reset in cycle 40 (RD0)
        set_fault(0, 0, '1, '0, 2'b00);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (39) @(posedge clk);
        #1;
        chk("pre_rst_oen", oen, 1);
        rst = 1;
        #1;
        chk("mid_rst_outs", {busy, done, pass, err_cnt, fail_addr, fail_phase, wdata, addr, wen, cen, oen}, 0);
        @(posedge clk);
        #1 rst = 0;
        tick(2);
        run_one(dc);
        chk("post_rst_done", dc, LAT);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_err", err_cnt, 0);
        tick(2);

        // randomized fault runs
        for (int r = 0; r < 12; r++) begin
            set_fault($urandom_range(7) == 0, $urandom_range(N - 1),
                      $urandom_range(1) ? 32'hFFFF_FFFF : 32'($urandom()),
                      ($urandom_range(3) == 0) ? 32'h0 : (32'h1 << $urandom_range(31)),
                      2'($urandom_range(3)));
            tick(1 + $urandom_range(4));
            run_one(dc);
            fb = first_bad(LAT);
            chk("rnd_err", err_cnt, exp_err(LAT));
            chk("rnd_addr", fail_addr, (fb < 0) ? 0 : fb % N);
            chk("rnd_phase", fail_phase, (fb >= N) ? 1 : 0);
            chk("rnd_pass", pass, (exp_err(LAT) == 0) ? 1 : 0);
            tick(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
